dmem_store_buffer: RTL

//   In-order store buffer between the memory-stage control and dmem.

---
 rtl/dmem_store_buffer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dmem_store_buffer.sv
// In-order store buffer sitting between the memory stage and dmem.
// Stores queue in a small circular FIFO. The buffer offers its oldest entry
// to dmem's write port on every cycle that it holds an entry. Loads read
// dmem directly and are forwarded from the youngest queued store that has
// an identical address. A load that partially overlaps a queued store must
// stall and retry until that store has drained.

`ifndef DATA_MEM_SIZE
`define DATA_MEM_SIZE 4096
`endif

module dmem_store_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] MEM_SIZE = 64'(`DATA_MEM_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    // store request
    input  logic                       st_valid,
    input  logic [63:0]                st_addr,
    input  logic [63:0]                st_data,
    output logic                       st_ready,
    output logic                       st_err,
    // load request
    input  logic                       ld_valid,
    input  logic [63:0]                ld_addr,
    output logic [63:0]                ld_data,
    output logic                       ld_fwd,
    output logic                       ld_stall,
    // dmem write port
    output logic [63:0]                mem_addr,
    output logic [63:0]                mem_data,
    output logic                       mem_write,
    // dmem read port
    output logic [63:0]                read_addr,
    input  logic [63:0]                read_data,
    // occupancy
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int          PTR_W    = $clog2(DEPTH);
    localparam int          CNT_W    = PTR_W + 1;
    localparam logic [63:0] MAX_ADDR = MEM_SIZE - 64'd8;

    // Queue storage. It has no reset because only the slots between head
    // and head+count are ever looked at.
    logic [63:0]      r_addr [DEPTH];
    logic [63:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_st_err;

    logic             w_st_addr_ok;
    logic             w_enq;
    logic             w_deq;

    assign w_st_addr_ok = (st_addr <= MAX_ADDR);
    assign st_ready     = (r_count != CNT_W'(DEPTH));
    assign w_enq        = st_valid & st_ready & w_st_addr_ok;
    assign w_deq        = (r_count != '0);

    // The write is gated by reset so that a store still queued when reset
    // is asserted is discarded and never committed to dmem.
    assign mem_write = w_deq & ~rst;
    assign mem_addr  = r_addr[r_head];
    assign mem_data  = r_data[r_head];
    assign read_addr = ld_addr;
    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign st_err    = r_st_err;

    // Capture an accepted store into the tail slot.
    always_ff @(posedge clk) begin
        if (!rst && w_enq) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
        end
    end

    // Update the pointers, the occupancy count and the one-cycle error pulse
    // for a rejected store.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_st_err <= 1'b0;
        end else begin
            r_st_err <= st_valid & ~w_st_addr_ok;
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-slot hazard detection. Slot gi is the gi-th oldest entry, so the
    // highest-numbered matching slot is the youngest store.
    logic [PTR_W-1:0] w_slot_idx [DEPTH];
    logic [DEPTH-1:0] w_slot_valid;
    logic [DEPTH-1:0] w_slot_overlap;
    logic [DEPTH-1:0] w_slot_exact;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [63:0] w_e_addr;
            assign w_slot_idx[gi]     = r_head + PTR_W'(gi);
            assign w_e_addr           = r_addr[w_slot_idx[gi]];
            assign w_slot_valid[gi]   = (CNT_W'(gi) < r_count);
            assign w_slot_overlap[gi] = w_slot_valid[gi]
                                      && (w_e_addr < ld_addr + 64'd8)
                                      && (ld_addr < w_e_addr + 64'd8);
            assign w_slot_exact[gi]   = w_slot_overlap[gi] && (w_e_addr == ld_addr);
        end
    endgenerate

    logic        w_partial;
    logic        w_fwd_hit;
    logic [63:0] w_fwd_data;

    // Find any partial overlap and pick the youngest exact match.
    always_comb begin
        w_partial  = |(w_slot_overlap & ~w_slot_exact);
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_exact[i]) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_slot_idx[i]];
            end
        end
    end

    assign ld_stall = ld_valid & w_partial;
    assign ld_fwd   = ld_valid & ~w_partial & w_fwd_hit;
    assign ld_data  = ld_fwd ? w_fwd_data : read_data;

endmodule
